// File: rtl/aes_pkg.sv
// +--------------------------------------------------------------------------+
// | aes_pkg : AES S-box table, xtime helper, key-size pairs, key-schedule FSM |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int c_aes128_nk = 4;
  localparam int c_aes128_nr = 10;
  localparam int c_aes192_nk = 6;
  localparam int c_aes192_nr = 12;
  localparam int c_aes256_nk = 8;
  localparam int c_aes256_nr = 14;

  // Element 0 sits at the MSBs, so c_sbox[b] is the forward S-box entry for b.
  localparam logic [0:255][7:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_subword.sv
// +--------------------------------------------------------------------------+
// | aes_subword : combinational 4-byte forward S-box lookup                   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {c_sbox[i_word[31:24]], c_sbox[i_word[23:16]],
                   c_sbox[i_word[15:8]],  c_sbox[i_word[7:0]]};

endmodule

`default_nettype wire

// File: rtl/aes_key_sched_seq.sv
// +--------------------------------------------------------------------------+
// | aes_key_sched_seq : word-per-cycle AES key expansion with round-key port  |
// | Optional macro AES_KS_ZEROIZE_EN adds a zeroize input. Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int NK = c_aes128_nk,
  parameter int NR = c_aes128_nr
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  input  logic                  start,
  input  logic [32*NK-1:0]      key,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  output logic [128*(NR+1)-1:0] fullkeys,
  input  logic [3:0]            rk_idx,
  output logic [127:0]          rk_out
);

  localparam int NW = 4 * (NR + 1);
  localparam int CW = $clog2(NW + 1);

  ks_state_t     r_state;
  ks_state_t     w_state_nxt;
  logic [31:0]   r_w   [NW];
  logic [31:0]   r_win [NK];   // sliding window: [0] = w[i-NK], [NK-1] = w[i-1]
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_mod;        // i % NK, tracked incrementally
  logic [7:0]    r_rcon;
  logic          r_keys_valid;
  logic [127:0]  r_rk_out;

  logic          w_zero;
  logic          w_accept;
  logic          w_last;
  logic [31:0]   w_prev;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic [127:0]  w_rk_sel;

`ifdef AES_KS_ZEROIZE_EN
  assign w_zero = zeroize;
`else
  assign w_zero = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && start && !w_zero;
  assign w_last   = (r_state == ST_EXPAND) && (r_cnt == CW'(NW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_EXPAND;
      ST_EXPAND: if (w_last)   w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
    if (w_zero) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    busy = (r_state == ST_EXPAND);
    done = w_last && !w_zero;
  end

  assign w_prev   = r_win[NK-1];
  assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0)                 w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_mod == 3'd4) w_temp = w_sub_out;
  end

  assign w_new = r_win[0] ^ w_temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NW; j++) r_w[j] <= '0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
      r_cnt        <= '0;
      r_mod        <= '0;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
    end else if (w_zero) begin
      for (int j = 0; j < NW; j++) r_w[j] <= '0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
      r_cnt        <= '0;
      r_mod        <= '0;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
    end else if (w_accept) begin
      for (int j = 0; j < NK; j++) begin
        r_w[j]   <= key[32*NK-1-32*j -: 32];
        r_win[j] <= key[32*NK-1-32*j -: 32];
      end
      r_cnt        <= CW'(NK);
      r_mod        <= '0;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
    end else if (r_state == ST_EXPAND) begin
      r_w[r_cnt] <= w_new;
      for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
      r_win[NK-1] <= w_new;
      r_cnt       <= r_cnt + 1'b1;
      r_mod       <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
      if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
      if (w_last)        r_keys_valid <= 1'b1;
    end
  end

  always_comb begin
    w_rk_sel = '0;
    for (int r = 0; r <= NR; r++)
      if (rk_idx == 4'(r)) w_rk_sel = {r_w[4*r], r_w[4*r+1], r_w[4*r+2], r_w[4*r+3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_rk_out <= '0;
    else if (w_zero) r_rk_out <= '0;
    else             r_rk_out <= w_rk_sel;
  end

  generate
    for (genvar j = 0; j < NW; j++) begin : g_fk
      assign fullkeys[32*NW-1-32*j -: 32] = r_w[j];
    end
  endgenerate

  assign keys_valid = r_keys_valid;
  assign rk_out     = r_rk_out;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_seq.sv
// Directed bench for aes_key_sched_seq: AES-128/192/256 instances against FIPS-197 vectors.
`default_nettype none

module tb_aes_key_sched_seq;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          zeroize = 1'b0;
  logic          start [3];
  logic          busy [3];
  logic          done [3];
  logic          kv [3];
  logic [3:0]    rk_idx [3];
  logic [127:0]  rk_out [3];
  logic [127:0]  key128 = '0;
  logic [191:0]  key192 = '0;
  logic [255:0]  key256 = '0;
  logic [1407:0] fk128;
  logic [1663:0] fk192;
  logic [1919:0] fk256;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_key_sched_seq #(.NK(4), .NR(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start[0]), .key(key128), .busy(busy[0]), .done(done[0]), .keys_valid(kv[0]),
    .fullkeys(fk128), .rk_idx(rk_idx[0]), .rk_out(rk_out[0]));

  aes_key_sched_seq #(.NK(6), .NR(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start[1]), .key(key192), .busy(busy[1]), .done(done[1]), .keys_valid(kv[1]),
    .fullkeys(fk192), .rk_idx(rk_idx[1]), .rk_out(rk_out[1]));

  aes_key_sched_seq #(.NK(8), .NR(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start[2]), .key(key256), .busy(busy[2]), .done(done[2]), .keys_valid(kv[2]),
    .fullkeys(fk256), .rk_idx(rk_idx[2]), .rk_out(rk_out[2]));

  // Caller must be 1 time unit after a rising edge; returns in the first IDLE cycle.
  task automatic run_expand(input int sel, input int exp_cyc, input bit disturb, input string name);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 0;
    start[sel] = 1'b1;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start[sel] = disturb && (cyc == 10 || cyc == 20);
      if (cyc == 1) begin
        n_vec++;
        if (busy[sel] !== 1'b1 || kv[sel] !== 1'b0) begin
          n_err++;
          $display("FAIL %s accept: busy=%b keys_valid=%b, want busy=1 keys_valid=0", name, busy[sel], kv[sel]);
        end
      end
      if (done[sel] === 1'b1) seen = 1;
    end
    n_vec++;
    if (!seen || cyc != exp_cyc) begin
      n_err++;
      $display("FAIL %s latency: done seen=%0d after %0d cycles, want %0d", name, seen, cyc, exp_cyc);
    end
    if (disturb) start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    n_vec++;
    if (busy[sel] !== 1'b0 || kv[sel] !== 1'b1 || done[sel] !== 1'b0) begin
      n_err++;
      $display("FAIL %s finish: busy=%b keys_valid=%b done=%b, want 0 1 0", name, busy[sel], kv[sel], done[sel]);
    end
  endtask

  task automatic check_rk(input int sel, input logic [3:0] idx, input logic [127:0] exp, input string name);
    rk_idx[sel] = idx;
    @(posedge clk); #1;
    n_vec++;
    if (rk_out[sel] !== exp) begin
      n_err++;
      $display("FAIL %s rk_out[%0d]: got %h want %h", name, idx, rk_out[sel], exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || kv[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset ctl: busy=%b done=%b keys_valid=%b, want 0 0 0", busy[0], done[0], kv[0]);
    end
    n_vec++;
    if (fk128 !== '0 || rk_out[0] !== '0) begin
      n_err++;
      $display("FAIL reset data: rk_out=%h, want 0", rk_out[0]);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aes128_fips();
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_expand(0, 40, 1'b0, "aes128_fips");
    n_vec++;
    if (fk128[1279 -: 32] !== 32'ha0fafe17) begin
      n_err++;
      $display("FAIL aes128_fips w4: got %h want a0fafe17", fk128[1279 -: 32]);
    end
    n_vec++;
    if (fk128[127:0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_err++;
      $display("FAIL aes128_fips round10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", fk128[127:0]);
    end
    check_rk(0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_fips");
    check_rk(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_fips");
    check_rk(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_fips");
    check_rk(0, 4'd11, 128'h0, "aes128_fips");
    check_rk(0, 4'd15, 128'h0, "aes128_fips");
  endtask

  task automatic test_aes128_seq_key();
    key128 = 128'h000102030405060708090a0b0c0d0e0f;
    run_expand(0, 40, 1'b0, "aes128_seq");
    check_rk(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "aes128_seq");
  endtask

  task automatic test_aes192();
    key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    run_expand(1, 46, 1'b0, "aes192");
    n_vec++;
    if (fk192[127:0] !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin
      n_err++;
      $display("FAIL aes192 fullkeys round12: got %h want a4970a331a78dc09c418c271e3a41d5d", fk192[127:0]);
    end
    check_rk(1, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, "aes192");
    check_rk(1, 4'd13, 128'h0, "aes192");
  endtask

  task automatic test_aes256();
    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_expand(2, 52, 1'b0, "aes256");
    check_rk(2, 4'd1,  128'h101112131415161718191a1b1c1d1e1f, "aes256");
    check_rk(2, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "aes256");
  endtask

  task automatic test_back_to_back();
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_expand(0, 40, 1'b1, "b2b_disturbed");
    n_vec++;
    if (fk128[127:0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_err++;
      $display("FAIL b2b_disturbed round10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", fk128[127:0]);
    end
    // Start in the very first IDLE cycle after done.
    key128 = 128'h000102030405060708090a0b0c0d0e0f;
    run_expand(0, 40, 1'b0, "b2b_next");
    check_rk(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "b2b_next");
  endtask

  task automatic test_reset_mid();
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_idx[0] = 4'd0;
    start[0] = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || kv[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid ctl: busy=%b done=%b keys_valid=%b, want 0 0 0", busy[0], done[0], kv[0]);
    end
    n_vec++;
    if (fk128 !== '0) begin
      n_err++;
      $display("FAIL reset_mid fullkeys: got %h want 0", fk128);
    end
    n_vec++;
    if (rk_out[0] !== '0) begin
      n_err++;
      $display("FAIL reset_mid rk_out: got %h want 0", rk_out[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_expand(0, 40, 1'b0, "after_reset");
    check_rk(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "after_reset");
  endtask

`ifdef AES_KS_ZEROIZE_EN
  task automatic test_zeroize();
    zeroize  = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    zeroize  = 1'b0;
    start[0] = 1'b0;
    n_vec++;
    if (fk128 !== '0 || rk_out[0] !== '0) begin
      n_err++;
      $display("FAIL zeroize data: rk_out=%h, want 0", rk_out[0]);
    end
    n_vec++;
    if (busy[0] !== 1'b0 || kv[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zeroize ctl: busy=%b keys_valid=%b done=%b, want 0 0 0", busy[0], kv[0], done[0]);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zeroize start_dropped: busy=%b want 0", busy[0]);
    end
  endtask
`endif

  initial begin
    for (int s = 0; s < 3; s++) begin
      start[s]  = 1'b0;
      rk_idx[s] = 4'd0;
    end
    test_reset();
    test_aes128_fips();
    test_aes128_seq_key();
    test_aes192();
    test_aes256();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_KS_ZEROIZE_EN
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/aes_key_sched_seq.md
Name: aes_key_sched_seq

Overview:
Sequential AES key-schedule engine that sits directly upstream of the AES encrypt datapath. It replaces the combinational keyExpansion with a word-per-cycle generator sharing a single 4-byte S-box. It stores all round keys and presents them on a flattened bus whose layout matches the encrypt stage's `fullkeys` input: round 0 at the MSBs, round Nr at [127:0]. Start/done handshake; a random-access round-key read port serves iterative cores.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8 → AES-128/192/256)
Nr, 10, number of rounds (10/12/14; must pair with Nk)
NW, 4*(Nr+1), derived localparam: total expanded words

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to expand `key`; sampled only when idle
key  input  32*Nk  cipher key, word 0 at MSBs; sampled in the start cycle only
busy  output  1  high while expanding
done  output  1  one-cycle pulse when the last word is written
keys_valid  output  1  level; high once expansion completes; cleared by the next accepted start
fullkeys  output  128*(Nr+1)  all round keys; round r occupies bits [128*(Nr+1)-1-128*r -: 128]
rk_idx  input  4  round-key select, 0..Nr
rk_out  output  128  registered round key rk_idx, 1-cycle read latency

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, keys_valid=0, fullkeys=0, rk_out=0, word counter=0, rcon=8'h01.
- FSM states: IDLE → EXPAND → IDLE.
- IDLE & start: load w[0..Nk-1] from key in the same edge; counter i=Nk; rcon=01; keys_valid←0; busy←1; go to EXPAND.
- EXPAND: each cycle compute w[i]:
  - temp=w[i-1].
  - If i%Nk==0: temp=SubWord(RotWord(temp))^{rcon,24'h0}, then rcon←xtime(rcon) (0x80→0x1b).
  - Else if Nk==8 and i%Nk==4: temp=SubWord(temp).
  - w[i]=w[i-Nk]^temp; i←i+1.
- When i==NW-1 is written: done=1 for that one cycle, busy←0, keys_valid←1, return to IDLE.
- Latency from the start edge to the done pulse: NW-Nk cycles. That is 40 cycles for AES-128, 46 for AES-192, 52 for AES-256.
- start while busy: ignored; no restart, no queueing.
- start asserted in the done cycle: ignored; FSM is not yet IDLE.
- start on the first IDLE cycle: accepted.
- fullkeys is updated word-by-word during EXPAND. Consumers must qualify it with keys_valid.
- rk_out ← fullkeys slice for rk_idx every cycle, regardless of state. rk_idx>Nr → rk_out=0.
- Reset mid-EXPAND: all state cleared; keys_valid=0; no done pulse.
- Counter width: clog2(NW+1); rcon is 8 bits.

Optional Feature:
AES_KS_ZEROIZE_EN
- Defined: adds input `zeroize` (1 bit).
  - A high sample in any state clears fullkeys, rk_out and the internal w storage to 0 on the next edge.
  - Forces IDLE, busy=0, keys_valid=0, with no done pulse.
  - zeroize has priority over start in the same cycle.
- Undefined: port absent. Key material persists until overwritten by the next expansion or reset.

Decomposition:
- Shared package aes_pkg:
  - S-box constant table and xtime function.
  - AES-128/192/256 (Nk, Nr) localparam pairs.
  - FSM state enum {IDLE, EXPAND}.
- One sub-module: aes_subword. Combinational 4-byte S-box lookup, 32 in / 32 out, instanced once. Reusable by the subBytes stage.

Test Plan:
- Reset, then AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
  - w[4]=a0fafe17.
  - done exactly 40 cycles after start.
  - fullkeys[127:0]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_idx=0 → rk_out=key one cycle later.
- AES-128 key 000102030405060708090a0b0c0d0e0f → round-10 key 13111d7fe3944a17f307a78b4d2b30c5; keys_valid=1 after done.
- Nk=6/Nr=12, key 000102…1617 → done after 46 cycles; round-12 key a4970a331a78dc09c418c271e3a41d5d.
- Nk=8/Nr=14, key 000102…1e1f → done after 52 cycles; round-14 key 24fc79ccbf0979e9371ac23c6d68de36.
- Second start pulses mid-EXPAND and in the done cycle → ignored; result and timing unchanged. start the cycle after done → accepted and keys_valid drops.
- rst_n low at cycle 20 of EXPAND → all outputs 0 asynchronously. A fresh start after release gives correct keys. With AES_KS_ZEROIZE_EN, zeroize+start together → outputs cleared and start dropped.
